// File: rtl/bcd_counter_display.sv
// Up/down counter driven by debounced push-buttons, with a sequential double-dabble
// converter feeding DIGITS active-low seven-segment digits.
module bcd_counter_display #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SATURATE        = 0,
    parameter int unsigned BLANK_LEADING   = 0
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic [WIDTH-1:0]      data_input,
    input  logic                  ctrl_load,
    input  logic                  ctrl_clear,
    input  logic                  ctrl_inc,
    input  logic                  ctrl_dec,
    output logic [WIDTH-1:0]      data_output_led,
    output logic [8*DIGITS-1:0]   data_output_sevensegs,
    output logic                  display_valid,
    output logic                  limit_pulse
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 8 * DIGITS;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    // Active-low seven-segment code for one BCD digit, DP off.
    function automatic logic [7:0] seg_lut(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Full display image; leading zeros optionally blanked, DP of top digit marks truncation.
    function automatic logic [SEG_W-1:0] encode(input logic [BCD_W-1:0] bcd, input logic trunc);
        logic [SEG_W-1:0] seg;
        logic             lead;
        logic [3:0]       digit;
        seg  = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
            if (digit != 4'd0) begin
                lead = 1'b0;
            end
            if ((BLANK_LEADING != 0) && lead && (i != 0)) begin
                seg[8*i +: 8] = 8'hFF;
            end else begin
                seg[8*i +: 8] = seg_lut(digit);
            end
        end
        if (trunc) begin
            seg[SEG_W-1] = 1'b0;
        end
        return seg;
    endfunction

    // ---------------- button conditioning (index 0 = inc, 1 = dec) ----------------
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            level_q, level_d;
    logic [1:0]            prev_q;
    logic [1:0]            pulse_q;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == level_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d[b]  = ~level_q[b];
                db_cnt_d[b] = '0;
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            prev_q   <= '0;
            pulse_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= {ctrl_dec, ctrl_inc};
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            prev_q   <= level_q;
            pulse_q  <= level_q & ~prev_q;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ---------------- counter ----------------
    logic [WIDTH-1:0] count_q, count_d;
    logic             limit_q, limit_d;
    logic             inc_pulse, dec_pulse;

    assign inc_pulse = pulse_q[0];
    assign dec_pulse = pulse_q[1];

    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        if (ctrl_clear) begin
            count_d = '0;
        end else if (ctrl_load) begin
            count_d = data_input;
        end else if (inc_pulse && !dec_pulse) begin
            limit_d = (count_q == CNT_MAX);
            if (!((count_q == CNT_MAX) && (SATURATE != 0))) begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (dec_pulse && !inc_pulse) begin
            limit_d = (count_q == '0);
            if (!((count_q == '0) && (SATURATE != 0))) begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    // ---------------- double-dabble conversion FSM ----------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  capt_q, capt_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              trunc_q, trunc_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              valid_q, valid_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        capt_d    = capt_q;
        last_d    = last_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        trunc_d   = trunc_q;
        seg_d     = seg_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != last_q) begin
                    shift_d   = count_q;
                    capt_d    = count_q;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    trunc_d   = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                trunc_d   = trunc_q | bcd_adj[BCD_W-1];
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                seg_d   = encode(bcd_q, trunc_q);
                last_d  = capt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered form of (state==IDLE && count==last_converted).
        valid_d = (state_d == S_IDLE) && (count_d == last_d);
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            capt_q    <= '0;
            last_q    <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            trunc_q   <= 1'b0;
            seg_q     <= encode('0, 1'b0);
            valid_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            capt_q    <= capt_d;
            last_q    <= last_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            trunc_q   <= trunc_d;
            seg_q     <= seg_d;
            valid_q   <= valid_d;
        end
    end

    assign data_output_led       = count_q;
    assign data_output_sevensegs = seg_q;
    assign display_valid         = valid_q;
    assign limit_pulse           = limit_q;

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Parametrised counter-and-display block: an up/down counter of WIDTH bits fed by debounced, edge-detected push-buttons, with synchronous load and clear. The count is converted to BCD by a sequential shift-add-3 (double-dabble) engine instead of combinational division, and the result drives DIGITS active-low seven-segment digits. It is the board-level top for DE0 counter experiments, sitting between raw switches/buttons and the LED/seven-segment pins.

## Interface
Parameters:
- WIDTH, 8, counter and data_input width (≥2)
- DIGITS, 4, number of seven-segment digits driven (≥1)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced level changes (≥1)
- SATURATE, 0, 0 = wrap at limits, 1 = hold at 0 / 2^WIDTH-1
- BLANK_LEADING, 0, 1 = leading-zero digits show blank (8'hFF)

Ports:
- clk  in  1  system clock, all state on rising edge
- async_reset  in  1  asynchronous, active-low reset
- data_input  in  WIDTH  load value
- ctrl_load  in  1  level, synchronous load (not debounced)
- ctrl_clear  in  1  level, synchronous clear (not debounced)
- ctrl_inc  in  1  raw button, increment on debounced rising edge
- ctrl_dec  in  1  raw button, decrement on debounced rising edge
- data_output_led  out  WIDTH  current count
- data_output_sevensegs  out  8*DIGITS  digit i at bits [8i+7:8i], i=0 least significant; bit 7 = DP, active-low
- display_valid  out  1  high when the display reflects data_output_led
- limit_pulse  out  1  one-cycle pulse when inc/dec wraps or is blocked by saturation

## Operation
- Input path per button: 2-flop synchroniser -> debouncer (counter resets whenever the synchronised sample equals the debounced level; debounced level flips once DEBOUNCE_CYCLES consecutive differing samples are seen) -> registered rising-edge detector (1-cycle pulse).
- Counter update priority per cycle: ctrl_clear (-> 0) > ctrl_load (-> data_input) > inc pulse and dec pulse both high (no change) > inc pulse (+1) > dec pulse (-1) > hold.
- Wrap mode: 2^WIDTH-1 +1 -> 0, 0 -1 -> 2^WIDTH-1, limit_pulse=1. Saturate mode: value held, limit_pulse=1. Load/clear never pulse limit_pulse.
- Conversion FSM, states IDLE, SHIFT, UPDATE:
  - IDLE: if count != last_converted, capture count into shift register, clear BCD register (4*DIGITS bits), go to SHIFT; display_valid=0 from this cycle.
  - SHIFT: exactly WIDTH cycles. Each cycle adds 3 to every BCD digit ≥5, then shifts {bcd, shift_reg} left by 1. A 1 shifted out of the top BCD digit sets a truncation flag.
  - UPDATE: encode digits to display register, last_converted <= captured value, go to IDLE.
- Encoding: 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90. Digit codes >9 cannot occur. With BLANK_LEADING=1, zero digits above the highest non-zero digit show FF; digit 0 is never blanked. Truncation clears DP (bit 7=0) of the most significant digit.
- Count changes during SHIFT do not disturb the conversion in progress. The new value is picked up in the next IDLE.
- display_valid = (state==IDLE) && (count==last_converted).

## Timing
- Reset (async_reset low): count 0, last_converted 0, state IDLE, debounced levels 0, edge pulses 0, limit_pulse 0, display_valid 1. Display shows digit 0 = C0, other digits C0 (BLANK_LEADING=0) or FF (BLANK_LEADING=1).
- Reset asserted mid-conversion aborts the conversion immediately. Release resumes from reset state with no spurious edge pulse, even if a button is held during release.
- Button latency: a raw input held high from cycle 0 produces an edge pulse in cycle DEBOUNCE_CYCLES+3, and the count changes at the end of that cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- Display latency: count changes at edge N. IDLE detects it in cycle N, so the new display is visible after edge N+WIDTH+2. display_valid returns high the same cycle.
- ctrl_load/ctrl_clear take effect at the next rising edge (1 cycle).

## Test plan
- Reset then release, DEBOUNCE_CYCLES=4, BLANK_LEADING=0 -> count 0, sevensegs 32'hC0C0C0C0, display_valid 1.
- ctrl_load=1 with data_input=8'd173 for one cycle -> count 173 next edge. display_valid low for WIDTH+2=10 cycles, then sevensegs 32'hC0F9F8B0.
- Raw ctrl_inc pulses of 3 cycles (ignored), then held 20 cycles -> exactly one increment in cycle 7, then count 174.
- Wrap mode: load 255, one debounced inc -> count 0, limit_pulse for 1 cycle. SATURATE=1: count stays 255, limit_pulse 1. Simultaneous inc/dec pulses -> no change, no pulse.
- DIGITS=2, load 8'd200 -> digits "00", MS digit DP low (8'h40), LS digit C0. BLANK_LEADING=1, load 7 -> FFFFFFF8 at DIGITS=4.
- Load 50, then load 99 during SHIFT -> display first shows 50, then 99 after a second full conversion. Assert reset during SHIFT -> immediate reset values.
